key_debounce8: RTL and testbench

Eight-channel synchroniser and debouncer for raw, asynchronous, active-low push-button lines. It sits directly upstream of the 8-to-3 priority encoder and drives the encoder's 8-bit active-low data input and its active-low enable. Glitch-free input reaches the encoder only after a key level has been stable for a programmable number of clock cycles. The block also flags each new key press with a one-cycle pulse for downstream event logic.

---
 rtl/key_debounce8_pkg.sv | 14 +
 rtl/key_debounce8_debounce_bit.sv | 52 +++++
 rtl/key_debounce8.sv | 58 +++++
 tb/tb_key_debounce8.sv | 137 +++++++++++++
 4 files changed

// File: rtl/key_debounce8_pkg.sv
// Shared constants and helpers for the eight-channel key debouncer.
package key_debounce8_pkg;

  localparam int unsigned KEY_N               = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

  // A debounced press is an accepted change from released (1) to pressed (0).
  function automatic logic isPressEdge(input logic syncLvl, input logic stableLvl,
                                       input logic atLimit);
    return (syncLvl != stableLvl) && atLimit && !syncLvl;
  endfunction

endpackage

// File: rtl/key_debounce8_debounce_bit.sv
// One key channel: two-flop synchroniser, stability counter, stable level and press pulse.
module key_debounce8_debounce_bit
  import key_debounce8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iKey,
  output logic oData,
  output logic oPress,
  output logic oPressNext_c
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             atLimit;

  // Counter has run out while the synchronised level still differs from the stable one.
  always_comb begin
    atLimit      = (cnt == CNT_LAST);
    oPressNext_c = isPressEdge(s2, oData, atLimit);
  end

  // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES edges.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      oData  <= 1'b1;
      cnt    <= '0;
      oPress <= 1'b0;
    end else begin
      s1     <= iKey;
      s2     <= s1;
      oPress <= oPressNext_c;
      if (s2 == oData) begin
        cnt <= '0;
      end else if (atLimit) begin
        oData <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_debounce8.sv
// Eight-channel key synchroniser/debouncer feeding an active-low priority encoder.
module key_debounce8
  import key_debounce8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [KEY_N-1:0] iKey,
  output logic [KEY_N-1:0] oData,
  output logic             oEI,
  output logic [KEY_N-1:0] oPress,
  output logic             oAnyPress
);

  localparam int unsigned       WARM_W    = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DEBOUNCE_CYCLES + 1);

  logic [KEY_N-1:0]  pressNext;
  logic [WARM_W-1:0] warmCnt;

  for (genvar i = 0; i < KEY_N; i++) begin : gBit
    key_debounce8_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBit (
      .iClk         (iClk),
      .iRst         (iRst),
      .iKey         (iKey[i]),
      .oData        (oData[i]),
      .oPress       (oPress[i]),
      .oPressNext_c (pressNext[i])
    );
  end

  // Hold the encoder disabled until a held key could have been debounced once.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      warmCnt <= '0;
      oEI     <= 1'b1;
    end else if (oEI) begin
      if (warmCnt == WARM_LAST) begin
        oEI <= 1'b0;
      end else begin
        warmCnt <= warmCnt + WARM_W'(1);
      end
    end
  end

  // Registered alongside the per-bit pulses so it lines up with oPress.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oAnyPress <= 1'b0;
    end else begin
      oAnyPress <= |pressNext;
    end
  end

endmodule

// File: tb/tb_key_debounce8.sv
// Directed, table-driven bench for key_debounce8 with DEBOUNCE_CYCLES = 4.
module tb_key_debounce8;
  import key_debounce8_pkg::*;

  typedef struct {
    logic [7:0] key;
    logic       rst;
    logic [7:0] data;
    logic       ei;
    logic [7:0] press;
    logic       any;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic [7:0] data;
  logic       ei;
  logic [7:0] press;
  logic       anyPress;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  key_debounce8 #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iKey      (key),
    .oData     (data),
    .oEI       (ei),
    .oPress    (press),
    .oAnyPress (anyPress)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic addRun(input int n, input logic [7:0] k, input logic r, input logic [7:0] d,
                        input logic e, input logic [7:0] p, input logic a);
    vec_t v;
    v.key = k; v.rst = r; v.data = d; v.ei = e; v.press = p; v.any = a;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    key = 8'hFF;

    // reset, warm-up with all keys released
    addRun(2, 8'hFF, 1, 8'hFF, 1, 8'h00, 0);
    addRun(5, 8'hFF, 0, 8'hFF, 1, 8'h00, 0);
    addRun(3, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);
    // key 3 press, accepted at edge 6
    addRun(5, 8'hF7, 0, 8'hFF, 0, 8'h00, 0);
    addRun(1, 8'hF7, 0, 8'hF7, 0, 8'h08, 1);
    addRun(2, 8'hF7, 0, 8'hF7, 0, 8'h00, 0);
    // key 3 release, no pulse
    addRun(5, 8'hFF, 0, 8'hF7, 0, 8'h00, 0);
    addRun(3, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);
    // key 5 three-cycle glitch is filtered
    addRun(3, 8'hDF, 0, 8'hFF, 0, 8'h00, 0);
    addRun(6, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);
    // keys 0 and 7 together
    addRun(5, 8'h7E, 0, 8'hFF, 0, 8'h00, 0);
    addRun(1, 8'h7E, 0, 8'h7E, 0, 8'h81, 1);
    addRun(1, 8'h7E, 0, 8'h7E, 0, 8'h00, 0);
    addRun(5, 8'hFF, 0, 8'h7E, 0, 8'h00, 0);
    addRun(2, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);
    // key 2 held, then reset with key still low
    addRun(5, 8'hFB, 0, 8'hFF, 0, 8'h00, 0);
    addRun(1, 8'hFB, 0, 8'hFB, 0, 8'h04, 1);
    addRun(1, 8'hFB, 0, 8'hFB, 0, 8'h00, 0);
    addRun(1, 8'hFB, 1, 8'hFF, 1, 8'h00, 0);
    addRun(5, 8'hFB, 0, 8'hFF, 1, 8'h00, 0);
    addRun(1, 8'hFB, 0, 8'hFB, 0, 8'h04, 1);
    addRun(1, 8'hFB, 0, 8'hFB, 0, 8'h00, 0);
    addRun(5, 8'hFF, 0, 8'hFB, 0, 8'h00, 0);
    addRun(2, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      key = vecs[i].key;
      rst = vecs[i].rst;
      tick();
      chk($sformatf("v%0d.data", i),  data,            vecs[i].data);
      chk($sformatf("v%0d.ei", i),    8'(ei),          8'(vecs[i].ei));
      chk($sformatf("v%0d.press", i), press,           vecs[i].press);
      chk($sformatf("v%0d.any", i),   8'(anyPress),    8'(vecs[i].any));
    end

    // bounce on key 4: low 3, high 1, then held low; latency counts from the final fall
    key = 8'hEF; tick(); tick(); tick();
    chk("bounce.nopress_early", press, 8'h00);
    key = 8'hFF; tick();
    key = 8'hEF; tick();
    n = 1;
    while (press == 8'h00 && n < 20) begin
      tick();
      n++;
    end
    chk("bounce.latency", 8'(n), 8'd6);
    chk("bounce.data", data, 8'hEF);
    chk("bounce.press", press, 8'h10);
    chk("bounce.any", 8'(anyPress), 8'h01);
    tick();
    chk("bounce.press_width", press, 8'h00);
    chk("bounce.any_width", 8'(anyPress), 8'h00);

    // four-cycle low pulse on key 6 is exactly long enough to be accepted
    key = 8'hAF; tick(); tick(); tick(); tick();
    key = 8'hEF;
    tick();
    chk("pulse4.before", data, 8'hEF);
    tick();
    chk("pulse4.data", data, 8'hAF);
    chk("pulse4.press", press, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
